// File: rtl/aes_ctr_core_pkg.sv
// Shared AES-128 constants, tables and FSM encoding for the CTR/ECB core.
// Also holds the one-step key-schedule helper used by the core.
package aes_pkg;

    localparam int BLOCK_BITS = 128;
    localparam int WORD_BITS  = 32;

    typedef enum logic [2:0] {
        NO_KEY,
        KEY_EXP,
        READY,
        RUN,
        HOLD
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Index r holds the constant for round key r; entry 0 is never used.
    localparam logic [7:0] RCON [11] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [WORD_BITS-1:0] sub_word(input logic [WORD_BITS-1:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [BLOCK_BITS-1:0] key_step(input logic [BLOCK_BITS-1:0] prev,
                                                       input logic [7:0]            rcon);
        logic [WORD_BITS-1:0] t, w0, w1, w2, w3;
        t  = sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h000000};
        w0 = prev[127:96] ^ t;
        w1 = prev[95:64]  ^ w0;
        w2 = prev[63:32]  ^ w1;
        w3 = prev[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_ctr_core_if.sv
// Block/key handshake bundle between a host (master) and the AES core (slave).
interface aes_ctr_core_if #(
    parameter int RND_SIZE = 128
);

    logic                i_key_load;
    logic [RND_SIZE-1:0] i_key;
    logic [RND_SIZE-1:0] i_iv;
    logic                i_mode;
    logic                i_valid;
    logic [RND_SIZE-1:0] i_data;
    logic                o_ready;
    logic                o_valid;
    logic [RND_SIZE-1:0] o_data;
    logic                i_ready;
    logic                o_key_rdy;
    logic                o_busy;

    modport master (
        output i_key_load, i_key, i_iv, i_mode, i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_key_rdy, o_busy
    );

    modport slave (
        input  i_key_load, i_key, i_iv, i_mode, i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_key_rdy, o_busy
    );

endinterface

// File: rtl/aes_ctr_core_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  logic [BLOCK_BITS-1:0] state_in,
    input  logic [BLOCK_BITS-1:0] round_key,
    input  logic                  mix_en,
    output logic [BLOCK_BITS-1:0] state_out
);

    // Block byte n (n=0 is the MSB) lives at row n%4, column n/4, stored at packed index 15-n.
    logic [15:0][7:0] in_b;
    logic [15:0][7:0] sb;
    logic [15:0][7:0] sr;
    logic [15:0][7:0] mc;

    assign in_b = state_in;

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        for (int n = 0; n < 16; n++) begin
            sb[15-n] = SBOX[in_b[15-n]];
        end
        for (int n = 0; n < 16; n++) begin
            sr[15-n] = sb[15 - (4 * (((n / 4) + (n % 4)) % 4) + (n % 4))];
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[15 - 4*c];
            a1 = sr[14 - 4*c];
            a2 = sr[13 - 4*c];
            a3 = sr[12 - 4*c];
            mc[15 - 4*c] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[14 - 4*c] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[13 - 4*c] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[12 - 4*c] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        state_out = (mix_en ? mc : sr) ^ round_key;
    end

endmodule

// File: rtl/aes_ctr_core.sv
// Iterative AES-128 encryptor with cached round keys, ECB and CTR (inc32) modes.
// One round or one key-schedule step per clock; result held until downstream takes it.
module aes_ctr_core
    import aes_pkg::*;
#(
    parameter int RND_SIZE = 128,
    parameter int NUM_RND  = 10,
    parameter int CNT_SIZE = 4
) (
    input logic           clk,
    input logic           rst_n,
    aes_ctr_core_if.slave bus
);

    state_t              state_q, state_d;
    logic [CNT_SIZE-1:0] rnd_cnt;
    logic [RND_SIZE-1:0] rk [NUM_RND+1];
    logic [RND_SIZE-1:0] key_work;
    logic [RND_SIZE-1:0] next_key;
    logic [RND_SIZE-1:0] ctr;
    logic [RND_SIZE-1:0] blk;
    logic [RND_SIZE-1:0] data_lat;
    logic [RND_SIZE-1:0] o_data_q;
    logic [RND_SIZE-1:0] round_out;
    logic                mode_lat;
    logic                key_take;
    logic                accept;
    logic                o_ready_c;
    logic                last_rnd;

    assign last_rnd = (rnd_cnt == CNT_SIZE'(NUM_RND));
    assign next_key = key_step(key_work, RCON[rnd_cnt]);

    aes_round u_round (
        .state_in  (blk),
        .round_key (rk[rnd_cnt]),
        .mix_en    (!last_rnd),
        .state_out (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NO_KEY;
        end else begin
            state_q <= state_d;
        end
    end

    // A key load outranks a block offered in the same cycle.
    always_comb begin
        state_d   = state_q;
        key_take  = 1'b0;
        accept    = 1'b0;
        o_ready_c = 1'b0;
        case (state_q)
            NO_KEY: begin
                if (bus.i_key_load) begin
                    key_take = 1'b1;
                    state_d  = KEY_EXP;
                end
            end
            KEY_EXP: begin
                if (last_rnd) state_d = READY;
            end
            READY: begin
                if (bus.i_key_load) begin
                    key_take = 1'b1;
                    state_d  = KEY_EXP;
                end else begin
                    o_ready_c = 1'b1;
                    if (bus.i_valid) begin
                        accept  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (last_rnd) state_d = HOLD;
            end
            HOLD: begin
                if (bus.i_key_load) begin
                    key_take = 1'b1;
                    state_d  = KEY_EXP;
                end else if (bus.i_ready) begin
                    state_d = READY;
                end
            end
            default: state_d = NO_KEY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_cnt  <= '0;
            key_work <= '0;
            ctr      <= '0;
            blk      <= '0;
            data_lat <= '0;
            mode_lat <= 1'b0;
            o_data_q <= '0;
        end else if (key_take) begin
            key_work <= bus.i_key;
            ctr      <= bus.i_iv;
            rnd_cnt  <= CNT_SIZE'(1);
        end else if (state_q == KEY_EXP) begin
            key_work <= next_key;
            rnd_cnt  <= last_rnd ? '0 : rnd_cnt + CNT_SIZE'(1);
        end else if (accept) begin
            data_lat <= bus.i_data;
            mode_lat <= bus.i_mode;
            blk      <= (bus.i_mode ? ctr : bus.i_data) ^ rk[0];
            rnd_cnt  <= CNT_SIZE'(1);
            if (bus.i_mode) ctr[31:0] <= ctr[31:0] + 32'd1;
        end else if (state_q == RUN) begin
            blk     <= round_out;
            rnd_cnt <= last_rnd ? '0 : rnd_cnt + CNT_SIZE'(1);
            if (last_rnd) o_data_q <= round_out ^ (mode_lat ? data_lat : '0);
        end
    end

    // Round-key cache: written only during expansion, never cleared by reset.
    always_ff @(posedge clk) begin
        if (key_take) begin
            rk[0] <= bus.i_key;
        end else if (state_q == KEY_EXP) begin
            rk[rnd_cnt] <= next_key;
        end
    end

    assign bus.o_ready   = o_ready_c;
    assign bus.o_valid   = (state_q == HOLD);
    assign bus.o_data    = o_data_q;
    assign bus.o_key_rdy = (state_q == READY) || (state_q == RUN) || (state_q == HOLD);
    assign bus.o_busy    = (state_q == KEY_EXP) || (state_q == RUN);

endmodule

// File: doc/aes_ctr_core.md
AES_CTR_CORE -- requirements
Module: aes_ctr_core

Interface
REQ-001 Parameter RND_SIZE, default 128: block/key width in bits; only 128 is supported.
REQ-002 Parameter NUM_RND, default 10: AES rounds (AES-128).
REQ-003 Parameter CNT_SIZE, default 4: round counter width; SHALL be >= clog2(NUM_RND+1).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_key_load  input  1  pulse to load i_key/i_iv and start key expansion.
REQ-007 i_key  input  RND_SIZE  cipher key.
REQ-008 i_iv  input  RND_SIZE  initial counter block for CTR mode.
REQ-009 i_mode  input  1  sampled at block accept; 0 = ECB, 1 = CTR.
REQ-010 i_valid  input  1  input block valid.
REQ-011 i_data  input  RND_SIZE  plaintext block.
REQ-012 o_ready  output  1  core accepts a block this cycle.
REQ-013 o_valid  output  1  o_data valid.
REQ-014 o_data  output  RND_SIZE  ciphertext block.
REQ-015 i_ready  input  1  downstream accepts o_data.
REQ-016 o_key_rdy  output  1  round keys cached and valid.
REQ-017 o_busy  output  1  high in KEY_EXP or RUN.

Function
REQ-018 FSM states SHALL be NO_KEY, KEY_EXP, READY, RUN and HOLD.
REQ-019 i_key_load SHALL be honoured only in NO_KEY, READY or HOLD, and ignored in KEY_EXP and RUN.
REQ-020 On an honoured i_key_load, the core SHALL discard any HOLD output, store rk[0]=i_key, load ctr=i_iv, clear o_key_rdy and enter KEY_EXP.
REQ-021 KEY_EXP SHALL compute rk[r] for r=1..NUM_RND, one per cycle (NUM_RND cycles), store them in a round-key register array, then set o_key_rdy=1 and enter READY.
REQ-022 o_ready SHALL equal (state==READY) & ~i_key_load (combinational); key load wins over a simultaneous i_valid.
REQ-023 Accept (i_valid & o_ready) SHALL latch i_data and i_mode, load the state register with (mode ? ctr : i_data) ^ rk[0], and enter RUN.
REQ-024 In RUN, one round per cycle for r=1..NUM_RND SHALL use rk[r], and the final round SHALL omit MixColumns.
REQ-025 The edge applying round NUM_RND SHALL load o_data with the ECB result, or the keystream XOR latched i_data in CTR mode; it SHALL set o_valid=1 and enter HOLD, so o_valid rises NUM_RND cycles after the accept edge.
REQ-026 In CTR mode, ctr[31:0] SHALL increment mod 2^32 at the accept edge (inc32), ctr[127:32] SHALL be unchanged, and 0xFFFFFFFF SHALL wrap to 0; ECB blocks SHALL not modify ctr.
REQ-027 In HOLD, o_data and o_valid SHALL be stable until i_ready; on o_valid & i_ready, o_valid SHALL clear and the state SHALL become READY (next accept possible the following cycle).
REQ-028 i_valid in any state other than READY SHALL be ignored; i_data need not be held by the source.
REQ-029 Cached round keys SHALL persist across unlimited blocks until the next honoured i_key_load.

Reset
REQ-030 While rst_n=0, the FSM SHALL be in NO_KEY with o_valid=0, o_ready=0, o_key_rdy=0, o_busy=0, o_data=0, ctr=0 and round counter 0; round-key storage need not be reset.
REQ-031 Reset asserted mid KEY_EXP or RUN SHALL abort the operation immediately with no output produced, and a key load SHALL be required after release.

Structure
REQ-032 Package aes_pkg SHALL hold the S-box table, Rcon table, FSM state encoding and block/word size constants.
REQ-033 One combinational sub-module, aes_round (SubBytes, ShiftRows, optional MixColumns, AddRoundKey), SHALL be instantiated once; the key-schedule step, FSM, counter and round-key array SHALL be inline.

Verification
REQ-034 Key 000102030405060708090a0b0c0d0e0f, ECB, data 00112233445566778899aabbccddeeff -> o_data 69c4e0d86a7b0430d8cdb78070b4c55a, with o_valid rising 10 cycles after accept.
REQ-035 Key 2b7e151628aed2a6abf7158809cf4f3c, ECB, data 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; a second block with the same key and no reload -> identical result.
REQ-036 Key 0, iv 0, CTR, data 0 -> 66e94bd4ef8a2c3b884cfa59ca342b2e; next CTR block equals ECB(00..01) XOR data.
REQ-037 iv low word FFFFFFFF, two CTR blocks -> second keystream equals ECB of iv with low word 00000000 and upper 96 bits unchanged.
REQ-038 i_ready held 0 for 5 cycles -> o_data stable, o_ready=0, and i_valid ignored; i_key_load with i_valid in READY -> key load taken, block not accepted.
REQ-039 rst_n asserted at round 5 of RUN -> all outputs 0 immediately; o_key_rdy=0 and o_ready=0 after release until a reload completes.
